jk_sync_counter: RTL and testbench
==================================

JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter bit width.
REQ-002 Parameter MODULUS, default 10, SHALL set the count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 clr  input  1  SHALL be the synchronous clear request.
REQ-006 load  input  1  SHALL be the synchronous parallel-load request.
REQ-007 load_val  input  WIDTH  SHALL be the value to load when load=1.
REQ-008 en  input  1  SHALL be the count enable.
REQ-009 up  input  1  SHALL select direction: 1=increment, 0=decrement.
REQ-010 q  output  WIDTH  SHALL be the registered count.
REQ-011 tc  output  1  SHALL be a registered one-cycle pulse marking a wrap.
REQ-012 load_err  output  1  SHALL be a registered one-cycle pulse marking a rejected load.

Function
REQ-013 Each bit q[i] SHALL be a JK stage: J_i = ~q[i] & n[i], K_i = q[i] & ~n[i], where n is the computed next count; the bit update SHALL follow hold/set/reset/toggle JK semantics.
REQ-014 Command priority per cycle SHALL be clr > load > en > hold.
REQ-015 clr=1: q <= 0; tc <= 0; load_err <= 0.
REQ-016 load=1, clr=0, load_val < MODULUS: q <= load_val; tc <= 0; load_err <= 0.
REQ-017 load=1, clr=0, load_val >= MODULUS: q holds; load_err <= 1 for one cycle; en ignored that cycle; tc <= 0.
REQ-018 en=1, up=1, no clr/load: q <= q+1, except q=MODULUS-1, where q <= 0 and tc <= 1.
REQ-019 en=1, up=0, no clr/load: q <= q-1, except q=0, where q <= MODULUS-1 and tc <= 1.
REQ-020 en=0, no clr/load: q holds; tc <= 0; load_err <= 0.
REQ-021 tc and load_err SHALL be high for exactly one cycle per event and SHALL assert in the same cycle q takes its wrapped or held value (latency 1 clock from the command).
REQ-022 Back-to-back wraps (MODULUS=2, en held) SHALL produce tc high on consecutive cycles.
REQ-023 Changing up while en=1 SHALL take effect on the next edge with no dead cycle.
REQ-024 Arithmetic SHALL be modulo MODULUS; q SHALL never hold a value >= MODULUS.
REQ-025 All outputs SHALL be driven directly from flops; no combinational input-to-output path.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force q=0, tc=0, load_err=0.
REQ-027 While rst_n=0, all inputs SHALL be ignored; the first active edge after rst_n deasserts SHALL apply normal priority.
REQ-028 Reset asserted mid-count SHALL discard any pending wrap; tc SHALL NOT pulse on release.

Verification
REQ-029 Reset, en=1, up=1, 12 edges -> q = 1..9,0,1,2; tc high only on the edge where q goes 9->0.
REQ-030 From q=0: en=1, up=0, 1 edge -> q=9, tc=1; next edge -> q=8, tc=0.
REQ-031 load=1, load_val=7 -> q=7, load_err=0; then load=1, load_val=12, en=1 -> q stays 7, load_err=1 for one cycle.
REQ-032 clr=1, load=1, en=1 at q=5 -> q=0, tc=0, load_err=0.
REQ-033 q=9, en=1, up=1, rst_n pulsed low between edges -> q=0 immediately; no tc pulse after release; the next edge gives q=1.
REQ-034 MODULUS=2, en=1, up=1 for 4 edges -> q = 1,0,1,0; tc = 0,1,0,1.

Source files
------------

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter built from JK flip-flop stages, with
// synchronous clear, range-checked parallel load, and registered wrap/error pulses.
module jk_sync_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_C = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             load_err_q, load_err_d;
    logic [WIDTH-1:0] n_c;
    logic [WIDTH-1:0] j_c, k_c;
    logic             load_ok_c;

    // Load is legal only when the value lies inside the count range
    assign load_ok_c = ({1'b0, load_val} < MOD_C);

    // Next count and pulse outputs: clr > load > en > hold
    always_comb begin
        n_c        = q_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (clr) begin
            n_c = '0;
        end else if (load) begin
            if (load_ok_c) begin
                n_c = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q_q == MAX_C) begin
                    n_c  = '0;
                    tc_d = 1'b1;
                end else begin
                    n_c = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    n_c  = MAX_C;
                    tc_d = 1'b1;
                end else begin
                    n_c = q_q - WIDTH'(1);
                end
            end
        end
    end

    assign j_c = ~q_q & n_c;
    assign k_c = q_q & ~n_c;

    // JK stage per bit: hold / reset / set / toggle
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            case ({j_c[i], k_c[i]})
                2'b00:   q_d[i] = q_q[i];
                2'b01:   q_d[i] = 1'b0;
                2'b10:   q_d[i] = 1'b1;
                default: q_d[i] = ~q_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q        <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = q_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Scoreboard bench: a decimal counter and a modulo-2 counter share the same
// stimulus; a modular-arithmetic model predicts both, a monitor checks each edge.
module tb_jk_sync_counter;

    typedef struct {
        logic [3:0] q;
        logic       tc;
        logic       le;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr, load, en, up;
    logic [3:0] load_val;
    logic [3:0] qa, qb;
    logic       tca, tcb, lea, leb;

    int   total = 0;
    int   bad   = 0;
    exp_t sa[$];
    exp_t sb[$];
    int   ma_q  = 0;
    int   mb_q  = 0;
    bit   done  = 0;

    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(qa), .tc(tca), .load_err(lea)
    );

    jk_sync_counter #(.WIDTH(4), .MODULUS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(qb), .tc(tcb), .load_err(leb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural reference: plain modulo arithmetic from the command rules
    task automatic model(input int m, inout int mq, output exp_t e);
        e.tc = 1'b0;
        e.le = 1'b0;
        if (clr) begin
            mq = 0;
        end else if (load) begin
            if (int'(load_val) < m) mq = int'(load_val);
            else                    e.le = 1'b1;
        end else if (en) begin
            if (up) begin
                e.tc = (mq + 1 >= m);
                mq   = (mq + 1) % m;
            end else begin
                e.tc = (mq == 0);
                mq   = (mq + m - 1) % m;
            end
        end
        e.q = 4'(mq);
    endtask

    // Called at a negedge: drive, optionally pulse reset, predict, then take the edge
    task automatic step(input logic c, input logic l, input logic [3:0] lv,
                        input logic e, input logic u, input bit rst_pulse);
        exp_t ea, eb;
        clr = c; load = l; load_val = lv; en = e; up = u;
        if (rst_pulse) begin
            #1 rst_n = 1'b0;
            #1;
            check("async_rst_q_a",  int'(qa),  0);
            check("async_rst_tc_a", int'(tca), 0);
            check("async_rst_q_b",  int'(qb),  0);
            check("async_rst_le_a", int'(lea), 0);
            #1 rst_n = 1'b1;
            ma_q = 0;
            mb_q = 0;
        end
        model(10, ma_q, ea);
        model(2,  mb_q, eb);
        sa.push_back(ea);
        sb.push_back(eb);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: one registered output word per edge, compared against the queue head
    always @(posedge clk) begin
        #1;
        if (!done && rst_n) begin
            if (sa.size() > 0) begin
                exp_t ea, eb;
                ea = sa.pop_front();
                eb = sb.pop_front();
                check("q_mod10",   int'(qa),  int'(ea.q));
                check("tc_mod10",  int'(tca), int'(ea.tc));
                check("lerr_mod10", int'(lea), int'(ea.le));
                check("q_mod2",    int'(qb),  int'(eb.q));
                check("tc_mod2",   int'(tcb), int'(eb.tc));
                check("lerr_mod2", int'(leb), int'(eb.le));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b1; up = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_q",  int'(qa),  0);
        check("reset_tc", int'(tca), 0);
        check("reset_le", int'(lea), 0);
        rst_n = 1'b1;

        // Twelve up-counts from zero: wrap 9->0 on the tenth edge
        for (int i = 0; i < 12; i++) step(0, 0, 4'd0, 1, 1, 0);
        // Down-count from zero wraps to 9, then 8
        step(1, 0, 4'd0, 0, 0, 0);
        step(0, 0, 4'd0, 1, 0, 0);
        step(0, 0, 4'd0, 1, 0, 0);
        // Legal load, then out-of-range load with en set
        step(0, 1, 4'd7,  0, 1, 0);
        step(0, 1, 4'd12, 1, 1, 0);
        step(0, 0, 4'd0,  0, 1, 0);
        // clr wins over load and en
        step(0, 1, 4'd5, 0, 1, 0);
        step(1, 1, 4'd3, 1, 1, 0);
        // Direction change with en held, no dead cycle
        step(0, 1, 4'd4, 0, 1, 0);
        step(0, 0, 4'd0, 1, 1, 0);
        step(0, 0, 4'd0, 1, 0, 0);
        step(0, 0, 4'd0, 1, 1, 0);
        // Mid-count reset at q=9 with a wrap pending
        step(0, 1, 4'd9, 0, 1, 0);
        step(0, 0, 4'd0, 1, 1, 1);
        step(0, 0, 4'd0, 1, 1, 0);
        // Modulo-2 back-to-back wraps from zero
        step(1, 0, 4'd0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 4'd0, 1, 1, 0);

        // Randomized commands
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(15) == 0), ($urandom_range(7) == 0),
                 4'($urandom_range(15)), ($urandom_range(3) != 0),
                 1'($urandom_range(1)), ($urandom_range(63) == 0));
        end

        @(posedge clk);
        #2;
        done = 1;
        check("scoreboard_drained", sa.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
